// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers four time-multiplexed channels from a single sample
// stream. A frame is four strobed slots, slot 0 is flagged by sync. The block
// hunts for sync, then tracks slots with a 2-bit counter, collecting samples in
// shadow registers. Only a complete, correctly framed set of four samples is
// moved to o0..o3, so the outputs never show a partial or misaligned frame.
module tdm_demux4 #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic [DATA_W-1:0] d,
  output logic [1:0]        s,
  output logic [DATA_W-1:0] o0,
  output logic [DATA_W-1:0] o1,
  output logic [DATA_W-1:0] o2,
  output logic [DATA_W-1:0] o3,
  output logic              valid,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] LAST_SLOT = 2'd3;

  state_t            state;
  logic [1:0]        slot;
  logic [DATA_W-1:0] sh [4];

  // Framing FSM, slot counter, shadow capture and output frame transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= 2'd0;
      // NOTE: the shadow registers are cleared too, so a post-reset frame
      // can never be assembled from samples captured before the reset.
      for (int i = 0; i < 4; i++) begin
        sh[i] <= '0;
      end
      o0       <= '0;
      o1       <= '0;
      o2       <= '0;
      o3       <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below
      // are overridden later in the same block and the last assignment wins.
      valid    <= 1'b0;
      sync_err <= 1'b0;

      if (en) begin
        unique case (state)
          HUNT: begin
            // Anything other than a marked slot 0 is noise while hunting.
            if (sync) begin
              sh[0] <= d;
              slot  <= 2'd1;
              state <= LOCKED;
            end
          end

          LOCKED: begin
            if (slot == 2'd0) begin
              if (sync) begin
                // Expected marker: start the next frame.
                sh[0] <= d;
                slot  <= 2'd1;
              end else begin
                // Missing marker: alignment is lost, drop back to hunting.
                sync_err <= 1'b1;
                slot     <= 2'd0;
                state    <= HUNT;
              end
            end else if (sync) begin
              // Early marker: the partial frame is abandoned and the marked
              // sample becomes slot 0 of a fresh frame. Stale shadows for
              // slots 1..3 are overwritten before they can be transferred.
              sync_err <= 1'b1;
              sh[0]    <= d;
              slot     <= 2'd1;
            end else begin
              sh[slot] <= d;
              slot     <= slot + 2'd1;
              if (slot == LAST_SLOT) begin
                // Frame complete: the slot-3 sample goes straight to o3
                // because its shadow is only being written on this edge.
                o0    <= sh[0];
                o1    <= sh[1];
                o2    <= sh[2];
                o3    <= d;
                valid <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  // Status outputs decoded directly from state registers.
  assign s      = slot;
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenarios plus randomized strobes for tdm_demux4,
// compared cycle by cycle against a frame-level model built on a queue of
// collected samples.
module tb_tdm_demux4;

  localparam int DATA_W = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              sync = 1'b0;
  logic [DATA_W-1:0] d = '0;
  logic [1:0]        s;
  logic [DATA_W-1:0] o0, o1, o2, o3;
  logic              valid, locked, sync_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: locked flag, samples of the frame in progress, last frame.
  bit       m_locked = 1'b0;
  bit       m_frame[$];
  bit [3:0] m_o      = 4'b0000;
  bit       m_valid  = 1'b0;
  bit       m_err    = 1'b0;
  int       valid_count = 0;

  tdm_demux4 #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .d        (d),
    .s        (s),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .valid    (valid),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frame-level rules: a frame is the sync-marked sample plus the next three
  // unmarked ones; anything breaking that pattern is an error.
  task automatic model_step(input bit r, input bit e, input bit sy, input bit dd);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!r) begin
      m_locked = 1'b0;
      m_frame.delete();
      m_o = 4'b0000;
    end else if (e) begin
      if (!m_locked) begin
        if (sy) begin
          m_locked = 1'b1;
          m_frame.delete();
          m_frame.push_back(dd);
        end
      end else if (m_frame.size() == 0) begin
        if (sy) begin
          m_frame.push_back(dd);
        end else begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end
      end else if (sy) begin
        m_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(dd);
      end else begin
        m_frame.push_back(dd);
        if (m_frame.size() == 4) begin
          m_o     = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
          m_valid = 1'b1;
          m_frame.delete();
        end
      end
    end
  endtask

  // Drive one cycle on the falling edge, then check just after the rising edge.
  task automatic apply(input bit r, input bit e, input bit sy, input bit dd);
    @(negedge clk);
    rst_n = r;
    en    = e;
    sync  = sy;
    d     = dd;
    model_step(r, e, sy, dd);
    @(posedge clk);
    #1;
    if (valid === 1'b1) valid_count++;
    check("s",        {30'd0, s}, {30'd0, (m_locked ? 2'(m_frame.size()) : 2'd0)});
    check("outputs",  {28'd0, o0, o1, o2, o3}, {28'd0, m_o});
    check("valid",    {31'd0, valid}, {31'd0, m_valid});
    check("sync_err", {31'd0, sync_err}, {31'd0, m_err});
    check("locked",   {31'd0, locked}, {31'd0, m_locked});
  endtask

  task automatic send_frame(input bit [3:0] p, input int gap);
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b1, (k == 0), p[3-k]);
      for (int g = 0; g < gap; g++) apply(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int vc;

    // Reset for two cycles with busy inputs to prove reset overrides them.
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset_outputs", {28'd0, o0, o1, o2, o3}, 32'd0);

    // Basic frame 1,0,1,1.
    vc = valid_count;
    send_frame(4'b1011, 0);
    check("basic_frame", {28'd0, o0, o1, o2, o3}, 32'hB);
    check("basic_one_valid", valid_count - vc, 1);

    // Same frame with 3-cycle en=0 gaps.
    vc = valid_count;
    send_frame(4'b1011, 3);
    check("gap_one_valid", valid_count - vc, 1);

    // Early marker on slot 2, then a clean frame.
    send_frame(4'b0110, 0);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("early_err_s", {30'd0, s}, 32'd1);
    check("early_hold", {28'd0, o0, o1, o2, o3}, 32'h6);
    send_frame(4'b1001, 0);
    check("after_early", {28'd0, o0, o1, o2, o3}, 32'h9);

    // Missing marker on slot 0, then strobes without sync are ignored.
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    check("missing_unlock", {31'd0, locked}, 32'd0);
    for (int k = 0; k < 5; k++) apply(1'b1, 1'b1, 1'b0, 1'(k));
    send_frame(4'b0101, 0);

    // Reset mid-frame, then the remainder of the frame without sync.
    vc = valid_count;
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_no_valid", valid_count - vc, 0);

    // Every 4-sample pattern, back to back.
    vc = valid_count;
    for (int p = 0; p < 16; p++) begin
      send_frame(4'(p), 0);
      check("exhaustive_frame", {28'd0, o0, o1, o2, o3}, 32'(p));
    end
    check("exhaustive_valids", valid_count - vc, 16);

    // Randomized strobes: mostly well-framed, with gaps, faults and resets.
    for (int n = 0; n < 1500; n++) begin
      bit r, e, sy;
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 3) != 0);
      sy = (m_frame.size() == 0 && $urandom_range(0, 9) != 0)
           || ($urandom_range(0, 24) == 0);
      apply(r, e, sy, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
- REQ-001 SHALL have parameter DATA_W, default 1: width of each channel sample.
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- REQ-004 SHALL have port en, input, 1: slot strobe; d and sync are sampled only on cycles with en=1.
- REQ-005 SHALL have port sync, input, 1: frame marker; high on the strobe carrying slot 0.
- REQ-006 SHALL have port d, input, DATA_W: time-multiplexed sample stream from the 4:1 mux side.
- REQ-007 SHALL have port s, output, 2: slot index expected on the next strobe.
- REQ-008 SHALL have ports o0, o1, o2, o3, output, DATA_W each: demultiplexed channel registers.
- REQ-009 SHALL have port valid, output, 1: one-cycle pulse when o0..o3 take a new complete frame.
- REQ-010 SHALL have port locked, output, 1: high while in LOCKED state.
- REQ-011 SHALL have port sync_err, output, 1: one-cycle pulse on a framing violation.

Function
- REQ-012 SHALL implement exactly two states, HUNT and LOCKED, plus a 2-bit slot counter and four DATA_W shadow registers sh0..sh3.
- REQ-013 SHALL do nothing on cycles with en=0: state, counter, shadows, and o0..o3 hold; valid and sync_err are 0.
- REQ-014 SHALL, in HUNT, ignore en=1 with sync=0.
- REQ-015 SHALL, in HUNT with en=1 and sync=1: sh0<=d, slot<=1, state<=LOCKED.
- REQ-016 SHALL, in LOCKED with en=1, sync=0 and slot in 1..3: sh[slot]<=d, slot<=slot+1 (3 wraps to 0).
- REQ-017 SHALL, in LOCKED with en=1 at slot 3, also load o0<=sh0, o1<=sh1, o2<=sh2, o3<=d (the current sample) and pulse valid=1 on the next cycle; latency from the slot-3 strobe edge to the outputs is one clock.
- REQ-018 SHALL, in LOCKED with en=1 and sync=1 at slot 0: sh0<=d, slot<=1, no error.
- REQ-019 SHALL, in LOCKED with en=1 and sync=0 at slot 0 (missing marker): pulse sync_err, go to HUNT, set slot<=0, and leave o0..o3 unchanged.
- REQ-020 SHALL, in LOCKED with en=1 and sync=1 at slot 1..3 (early marker): pulse sync_err, discard the partial frame, sh0<=d, slot<=1, and stay LOCKED with no valid pulse.
- REQ-021 SHALL let o0..o3 change only on a valid pulse; a partial or discarded frame SHALL never reach the outputs.
- REQ-022 SHALL drive s equal to the slot counter, which is 0 in HUNT.
- REQ-023 SHALL give valid and sync_err the same single-cycle pulse semantics; the two SHALL never be high in the same cycle.
- REQ-024 SHALL drive locked=1 exactly when state=LOCKED.

Reset
- REQ-025 SHALL, on any clk edge with rst_n=0, set state=HUNT, slot=0, sh0..sh3=0, o0..o3=0, valid=0, sync_err=0, and locked=0, overriding en, sync, and d.
- REQ-026 SHALL, when reset is asserted mid-frame, lose the partial frame; after rst_n returns high the block SHALL require a new sync before any capture.

Verification
- REQ-027 Scenario: DATA_W=1, rst_n=0 for 2 cycles, then en=1 with sync only on slot 0 and d=1,0,1,1 -> locked=1 after the first strobe, valid pulses once, {o0,o1,o2,o3}=1,0,1,1, and s sequences 1,2,3,0.
- REQ-028 Scenario: the same frame with en=0 gaps of 3 cycles between strobes -> identical outputs; valid pulses only after the 4th strobe; s holds during the gaps.
- REQ-029 Scenario: after lock, sync=1 on slot 2 -> sync_err pulses, o0..o3 hold their previous frame, s=1 next, and the following 4-slot frame decodes correctly.
- REQ-030 Scenario: after lock, sync=0 on slot 0 -> sync_err pulses, locked=0, s=0, and strobes are ignored until the next sync.
- REQ-031 Scenario: rst_n=0 asserted after 2 slots of a frame -> all outputs 0 next cycle; the remaining 2 slots, sent without sync, produce no valid.
- REQ-032 Scenario: exhaustive run over all 16 d patterns per frame, back-to-back frames with sync each frame -> each valid matches the frame sent, one valid per frame, and sync_err never asserts.
